// File: rtl/four_func_net.sv
// four_func_net: registered 8-bit ADD/SUB/AND/XOR unit.
// The datapath is written as an explicit gate-level netlist. Every adder
// cell, operand-inversion gate and mux gate is a named instance, so each
// internal net can be addressed as a stuck-at fault site.
module four_func_net #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       func,
    output logic [WIDTH:0]   out,
    output logic             out_valid,
    output logic             zero
);

    // Gate-level nets, one bit per addressable fault site.
    wire [WIDTH-1:0] b_x_s;      // b conditionally inverted for SUB
    wire [WIDTH:0]   carry_s;    // ripple chain, carry_s[0] is carry-in
    wire [WIDTH-1:0] sum_s;      // adder sum
    wire [WIDTH-1:0] and_s;      // a & b
    wire [WIDTH-1:0] xor_s;      // a ^ b
    wire [WIDTH-1:0] m0_s;       // mux leg: ADD
    wire [WIDTH-1:0] m1_s;       // mux leg: SUB
    wire [WIDTH-1:0] m2_s;       // mux leg: AND
    wire [WIDTH-1:0] m3_s;       // mux leg: XOR
    wire [WIDTH-1:0] m01_s;
    wire [WIDTH-1:0] m23_s;
    wire [WIDTH-1:0] value_s;    // selected low WIDTH bits
    wire             f0_n_s;
    wire             f1_n_s;
    wire             sel0_s;
    wire             sel1_s;
    wire             sel2_s;
    wire             sel3_s;
    wire             cb_raw_s;   // carry for ADD, borrow (= ~carry-out) for SUB
    wire             cb_s;       // carry/borrow gated off for logic functions

    // Function decode for the one-hot 4:1 mux.
    not  u_f0_n (f0_n_s, func[0]);
    not  u_f1_n (f1_n_s, func[1]);
    and  u_sel0 (sel0_s, f1_n_s, f0_n_s);
    and  u_sel1 (sel1_s, f1_n_s, func[0]);
    and  u_sel2 (sel2_s, func[1], f0_n_s);
    and  u_sel3 (sel3_s, func[1], func[0]);

    // SUB is a + ~b + 1: func[0] is the carry-in.
    buf  u_cin  (carry_s[0], func[0]);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            xor     u_binv (b_x_s[i], b[i], func[0]);
            fa_cell u_fa   (.a_i(a[i]), .b_i(b_x_s[i]), .ci_i(carry_s[i]),
                            .s_o(sum_s[i]), .co_o(carry_s[i+1]));
            and     u_and  (and_s[i], a[i], b[i]);
            xor     u_xor  (xor_s[i], a[i], b[i]);
            and     u_m0   (m0_s[i], sum_s[i], sel0_s);
            and     u_m1   (m1_s[i], sum_s[i], sel1_s);
            and     u_m2   (m2_s[i], and_s[i], sel2_s);
            and     u_m3   (m3_s[i], xor_s[i], sel3_s);
            or      u_m01  (m01_s[i], m0_s[i], m1_s[i]);
            or      u_m23  (m23_s[i], m2_s[i], m3_s[i]);
            or      u_mo   (value_s[i], m01_s[i], m23_s[i]);
        end
    endgenerate

    // Borrow is the inverted carry-out when subtracting; logic ops force it low.
    xor  u_cb   (cb_raw_s, carry_s[WIDTH], func[0]);
    and  u_cbg  (cb_s, cb_raw_s, f1_n_s);

    logic [WIDTH:0] out_d;
    logic [WIDTH:0] out_q;
    logic           zero_d;
    logic           zero_q;
    logic           out_valid_d;
    logic           out_valid_q;

    // Next-state: capture on in_valid, otherwise hold result and drop valid.
    always_comb begin
        out_d       = out_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_d       = {cb_s, value_s};
            zero_d      = (value_s == {WIDTH{1'b0}});
            out_valid_d = 1'b1;
        end else begin
            out_d       = out_q;
            zero_d      = zero_q;
            out_valid_d = 1'b0;
        end
    end

    // Output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= {(WIDTH+1){1'b0}};
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

// One full-adder cell built from primitive gates.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    wire p_s;
    wire g_s;
    wire pc_s;

    xor u_p  (p_s, a_i, b_i);
    xor u_s  (s_o, p_s, ci_i);
    and u_g  (g_s, a_i, b_i);
    and u_pc (pc_s, p_s, ci_i);
    or  u_co (co_o, g_s, pc_s);
endmodule

// File: tb/tb_four_func_net.sv
// Directed-vector bench for four_func_net plus reset/hold sequences and a
// short random sweep against a behavioural reference.
module tb_four_func_net;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] func;
    logic [8:0] out;
    logic       out_valid;
    logic       zero;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] func;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl [14];

    four_func_net #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .func(func),
        .out(out), .out_valid(out_valid), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic [1:0] f);
        logic [8:0] r;
        case (f)
            2'b00:   r = {1'b0, x} + {1'b0, y};
            2'b01:   r = {(x < y), 8'(x - y)};
            2'b10:   r = {1'b0, x & y};
            default: r = {1'b0, x ^ y};
        endcase
        return r;
    endfunction

    initial begin
        logic [8:0] last;
        logic [8:0] e;

        n_cmp = 0;
        n_bad = 0;
        tbl[0]  = '{8'h3C, 8'h45, 2'b00, 9'h081};
        tbl[1]  = '{8'hFF, 8'h01, 2'b00, 9'h100};
        tbl[2]  = '{8'h50, 8'h20, 2'b01, 9'h030};
        tbl[3]  = '{8'h00, 8'h01, 2'b01, 9'h1FF};
        tbl[4]  = '{8'h7A, 8'h7A, 2'b01, 9'h000};
        tbl[5]  = '{8'hF0, 8'h3C, 2'b10, 9'h030};
        tbl[6]  = '{8'hF0, 8'h3C, 2'b11, 9'h0CC};
        tbl[7]  = '{8'hFF, 8'hFF, 2'b00, 9'h1FE};
        tbl[8]  = '{8'hFF, 8'h00, 2'b01, 9'h0FF};
        tbl[9]  = '{8'h01, 8'hFF, 2'b01, 9'h102};
        tbl[10] = '{8'hFF, 8'hFF, 2'b10, 9'h0FF};
        tbl[11] = '{8'hAA, 8'hAA, 2'b11, 9'h000};
        tbl[12] = '{8'h00, 8'h00, 2'b00, 9'h000};
        tbl[13] = '{8'h80, 8'h7F, 2'b01, 9'h001};

        rst_n = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; func = 2'b00;

        // Asynchronous reset mid-cycle: outputs clear without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out",   out, 9'h000);
        chk("rst_valid", {8'h00, out_valid}, 9'h000);
        chk("rst_zero",  {8'h00, zero}, 9'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_out",   out, 9'h000);
        chk("idle_valid", {8'h00, out_valid}, 9'h000);

        // Back-to-back table vectors, one per cycle.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; func = tbl[i].func;
            @(posedge clk); #1;
            e = tbl[i].exp;
            chk($sformatf("vec%0d_out", i), out, e);
            chk($sformatf("vec%0d_zero", i), {8'h00, zero}, {8'h00, (e[7:0] == 8'h00)});
            chk($sformatf("vec%0d_valid", i), {8'h00, out_valid}, 9'h001);
        end
        last = tbl[13].exp;

        // Drop in_valid: result and zero hold, valid clears.
        @(negedge clk);
        in_valid = 1'b0; a = 8'h11; b = 8'h22; func = 2'b00;
        @(posedge clk); #1;
        chk("hold_out",   out, last);
        chk("hold_zero",  {8'h00, zero}, 9'h000);
        chk("hold_valid", {8'h00, out_valid}, 9'h000);

        // Reset asserted during a valid operation: reset wins.
        @(negedge clk);
        in_valid = 1'b1; a = 8'h12; b = 8'h34; func = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_out_now", out, 9'h000);
        @(posedge clk); #1;
        chk("rst2_out_held", out, 9'h000);
        chk("rst2_valid",    {8'h00, out_valid}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1; a = 8'h03; b = 8'h04; func = 2'b00;
        @(posedge clk); #1;
        chk("first_cap_out",   out, 9'h007);
        chk("first_cap_valid", {8'h00, out_valid}, 9'h001);

        // Random sweep against the behavioural reference.
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 8'($urandom_range(255, 0));
            b = 8'($urandom_range(255, 0));
            func = 2'($urandom_range(3, 0));
            e = model(a, b, func);
            @(posedge clk); #1;
            chk("rand_out",  out, e);
            chk("rand_zero", {8'h00, zero}, {8'h00, (e[7:0] == 8'h00)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
